// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// two's-complement negation helper and a WIDTH/STEPS legality check.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Widest operand the negation helper can handle; callers zero-extend into it.
  localparam int unsigned DIV_MAX_W = 128;

  // Two's-complement negate. The caller truncates back to its own width;
  // the low bits of the wide negation equal the narrow negation.
  function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] v);
    return ~v + {{(DIV_MAX_W-1){1'b0}}, 1'b1};
  endfunction

  // True when the divider can be built with this width / bits-per-cycle pair.
  function automatic bit cfg_legal(input int w, input int s);
    if ((w < 4) || ((w % 2) != 0) || (w > int'(DIV_MAX_W)) || (s < 1) || (s > w)) begin
      return 1'b0;
    end else begin
      return ((w % s) == 0);
    end
  endfunction

endpackage

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shifts the next dividend bit
// into the partial remainder and keeps the trial subtraction when it does
// not borrow. The quotient bit is the inverted borrow.
module divisor_paso
  import divisor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift, trial-subtract, restore on borrow
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, den};
    q_bit     = ~diff_s[WIDTH];
    if (q_bit) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divisor_secuencial_param.sv
// Multi-cycle signed/unsigned integer divider with START/BUSY/DONE handshake.
// Magnitudes are divided with STEPS chained restoring steps per cycle; signs
// are applied in the FIX state (truncation toward zero, remainder follows
// the dividend). Divide-by-zero skips CALC and returns all-ones / NUM.
// Optional macro DIVISOR_OVF_EN adds the OVF flag for most-negative / -1.
module divisor_secuencial_param
  import divisor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] coc,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             busy,
  output logic             div0
`ifdef DIVISOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / STEPS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
`ifdef DIVISOR_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  if (!cfg_legal(WIDTH, STEPS)) begin : g_bad_cfg
    $error("divisor_secuencial_param: illegal WIDTH/STEPS combination");
  end

  div_state_e       state_r;
  div_state_e       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;        // partial remainder
  logic [WIDTH-1:0] quo_r;        // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] den_r;        // divisor magnitude
  logic             qneg_r;
  logic             rneg_r;
  logic             div0_pend_r;
`ifdef DIVISOR_OVF_EN
  logic             ovf_pend_r;
`endif

  logic             num_neg_s;
  logic             den_neg_s;
  logic             den_zero_s;
  logic [WIDTH-1:0] num_mag_s;
  logic [WIDTH-1:0] den_mag_s;
  logic [STEPS-1:0] qbit_s;
  logic [WIDTH-1:0] rem_calc_s;
  logic [WIDTH-1:0] quo_calc_s;
  logic [WIDTH-1:0] coc_fix_s;
  logic [WIDTH-1:0] res_fix_s;

  // Operand sign decode and magnitude extraction at request time
  always_comb begin
    num_neg_s  = signed_mode & num[WIDTH-1];
    den_neg_s  = signed_mode & den[WIDTH-1];
    den_zero_s = (den == ZERO_W);
    if (num_neg_s) begin
      num_mag_s = WIDTH'(twos_neg(DIV_MAX_W'(num)));
    end else begin
      num_mag_s = num;
    end
    if (den_neg_s) begin
      den_mag_s = WIDTH'(twos_neg(DIV_MAX_W'(den)));
    end else begin
      den_mag_s = den;
    end
  end

  // Chain of STEPS restoring steps; each consumes the next dividend MSB
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [WIDTH-1:0] rem_in_s;
    logic [WIDTH-1:0] rem_out_s;
    logic             q_s;
    if (g == 0) begin : g_first
      assign rem_in_s = rem_r;
    end else begin : g_next
      assign rem_in_s = g_step[g-1].rem_out_s;
    end
    divisor_paso #(.WIDTH(WIDTH)) u_paso (
      .rem_in  (rem_in_s),
      .bit_in  (quo_r[WIDTH-1-g]),
      .den     (den_r),
      .rem_out (rem_out_s),
      .q_bit   (q_s)
    );
    assign qbit_s[g] = q_s;
  end

  assign rem_calc_s = g_step[STEPS-1].rem_out_s;

  // Shift the new quotient bits in, earliest step ending up most significant
  always_comb begin
    quo_calc_s = quo_r;
    for (int i = 0; i < STEPS; i++) begin
      quo_calc_s = {quo_calc_s[WIDTH-2:0], qbit_s[i]};
    end
  end

  // Apply result signs to the unsigned quotient/remainder
  always_comb begin
    if (qneg_r) begin
      coc_fix_s = WIDTH'(twos_neg(DIV_MAX_W'(quo_r)));
    end else begin
      coc_fix_s = quo_r;
    end
    if (rneg_r) begin
      res_fix_s = WIDTH'(twos_neg(DIV_MAX_W'(rem_r)));
    end else begin
      res_fix_s = rem_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && den_zero_s) begin
          state_next_s = FIX;
        end else if (start) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered results/handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= ZERO_W;
      quo_r       <= ZERO_W;
      den_r       <= ZERO_W;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      div0_pend_r <= 1'b0;
      coc         <= ZERO_W;
      res         <= ZERO_W;
      done        <= 1'b0;
      busy        <= 1'b0;
      div0        <= 1'b0;
`ifdef DIVISOR_OVF_EN
      ovf_pend_r  <= 1'b0;
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            cnt_r       <= CNT_LOAD;
            rem_r       <= ZERO_W;
            den_r       <= den_mag_s;
            qneg_r      <= num_neg_s ^ den_neg_s;
            rneg_r      <= num_neg_s;
            div0_pend_r <= den_zero_s;
            // With a zero divisor CALC is skipped, so keep the raw dividend for RES
            quo_r       <= den_zero_s ? num : num_mag_s;
`ifdef DIVISOR_OVF_EN
            ovf_pend_r  <= signed_mode & (num == MOST_NEG) & (den == ALL_ONES);
`endif
          end
        end
        CALC: begin
          rem_r <= rem_calc_s;
          quo_r <= quo_calc_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (div0_pend_r) begin
            coc  <= ALL_ONES;
            res  <= quo_r;
            div0 <= 1'b1;
`ifdef DIVISOR_OVF_EN
            ovf  <= 1'b0;
`endif
          end else begin
            coc  <= coc_fix_s;
            res  <= res_fix_s;
            div0 <= 1'b0;
`ifdef DIVISOR_OVF_EN
            ovf  <= ovf_pend_r;
`endif
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
